// File: rtl/bus_master_interface.sv
// Master-side bus interface: turns a held pipeline access into the active-low
// request/grant/strobe/ready bus handshake, with read-data capture and slave timeout.
module bus_master_interface #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_address,
    input  logic              req_read_write,
    input  logic [DATA_W-1:0] req_write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              bus_error,
    output logic              bus_request_,
    input  logic              bus_grant_,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_address_strobe_,
    output logic              bus_read_write,
    output logic [DATA_W-1:0] bus_write_data,
    input  logic [DATA_W-1:0] bus_read_data,
    input  logic              bus_ready_
);

    typedef enum logic [1:0] {StIdle, StRequest, StAccess, StStall} state_e;

    localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [7:0]          count_q, count_d;
    logic                request_n_q, request_n_d;
    logic                strobe_n_q, strobe_n_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                error_q, error_d;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        request_n_d = request_n_q;
        strobe_n_d  = strobe_n_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        error_d     = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = req & ~flush;
                if (req && !flush) begin
                    request_n_d = 1'b0;
                    addr_d      = req_address;
                    rw_d        = req_read_write;
                    wdata_d     = req_write_data;
                    state_d     = StRequest;
                end
            end
            StRequest: begin
                busy = 1'b1;
                if (flush) begin
                    request_n_d = 1'b1;
                    strobe_n_d  = 1'b1;
                    rw_d        = 1'b1;
                    addr_d      = '0;
                    wdata_d     = '0;
                    state_d     = StIdle;
                end else if (!bus_grant_) begin
                    strobe_n_d = 1'b0;
                    count_d    = '0;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                busy       = 1'b1;
                strobe_n_d = 1'b1;
                // Ready has priority over the terminal count, so a late reply is never an error.
                if (!bus_ready_ || (count_q == LastCount)) begin
                    request_n_d = 1'b1;
                    rw_d        = 1'b1;
                    addr_d      = '0;
                    wdata_d     = '0;
                    state_d     = stall ? StStall : StIdle;
                    if (!bus_ready_) begin
                        if (rw_q) begin
                            rdata_d = bus_read_data;
                        end
                    end else begin
                        rdata_d = '0;
                        error_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            StStall: begin
                if (!stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            request_n_q <= 1'b1;
            strobe_n_q  <= 1'b1;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            request_n_q <= request_n_d;
            strobe_n_q  <= strobe_n_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    assign read_data           = rdata_q;
    assign bus_error           = error_q;
    assign bus_request_        = request_n_q;
    assign bus_address         = addr_q;
    assign bus_address_strobe_ = strobe_n_q;
    assign bus_read_write      = rw_q;
    assign bus_write_data      = wdata_q;

endmodule

// File: tb/tb_bus_master_interface.sv
// Randomized bench for bus_master_interface: a reactive slave/arbiter drives the bus,
// expectations are queued at issue and a separate monitor checks them as the DUT responds.
module tb_bus_master_interface;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int T  = 4;

    logic          clock, reset, stall, flush, req;
    logic [AW-1:0] req_address;
    logic          req_read_write;
    logic [DW-1:0] req_write_data, read_data;
    logic          busy, bus_error, bus_request_, bus_grant_;
    logic [AW-1:0] bus_address;
    logic          bus_address_strobe_, bus_read_write;
    logic [DW-1:0] bus_write_data, bus_read_data;
    logic          bus_ready_;

    bus_master_interface #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .req(req),
        .req_address(req_address), .req_read_write(req_read_write),
        .req_write_data(req_write_data), .read_data(read_data), .busy(busy),
        .bus_error(bus_error), .bus_request_(bus_request_), .bus_grant_(bus_grant_),
        .bus_address(bus_address), .bus_address_strobe_(bus_address_strobe_),
        .bus_read_write(bus_read_write), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .bus_ready_(bus_ready_)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [DW-1:0] wdata;
    } bus_exp_t;

    typedef struct {
        int            busy_len;
        logic [DW-1:0] rdata;
        logic          err;
    } res_exp_t;

    bus_exp_t      bus_q[$];
    res_exp_t      res_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            issued = 0;
    int            req_falls = 0;
    logic [DW-1:0] model_rdata = '0;
    bit            mon_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples just after the falling edge, when driver inputs have settled.
    logic     prev_strobe = 1'b1;
    logic     prev_req_n  = 1'b1;
    logic     prev_busy   = 1'b0;
    bit       err_chk     = 0;
    int       run_len     = 0;
    bus_exp_t mbe;
    res_exp_t mre;

    always @(negedge clock) begin
        #1;
        if (mon_en) begin
            if (!bus_address_strobe_) begin
                check("strobe_one_cycle", 64'(prev_strobe), 64'd1);
                if (bus_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL strobe_unexpected: got strobe low, required no strobe");
                end else begin
                    mbe = bus_q.pop_front();
                    check("bus_address", 64'(bus_address), 64'(mbe.addr));
                    check("bus_read_write", 64'(bus_read_write), 64'(mbe.rw));
                    check("bus_write_data", 64'(bus_write_data), 64'(mbe.wdata));
                    check("request_low_at_strobe", 64'(bus_request_), 64'd0);
                end
            end
            if (prev_req_n && !bus_request_) begin
                req_falls++;
                check("no_reissue", 64'(req_falls <= issued), 64'd1);
            end
            if (err_chk) begin
                check("error_pulse_width", 64'(bus_error), 64'd0);
                err_chk = 0;
            end
            if (busy) begin
                run_len++;
            end else if (prev_busy) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL busy_unexpected: got busy run %0d, required none", run_len);
                end else begin
                    mre = res_q.pop_front();
                    check("busy_cycles", 64'(run_len), 64'(mre.busy_len));
                    check("read_data", 64'(read_data), 64'(mre.rdata));
                    check("bus_error", 64'(bus_error), 64'(mre.err));
                    check("request_released", 64'(bus_request_), 64'd1);
                    err_chk = 1;
                end
                run_len = 0;
            end
        end
        prev_strobe = bus_address_strobe_;
        prev_req_n  = bus_request_;
        prev_busy   = busy;
    end

    // One pipeline access plus the slave/arbiter behaviour for it: grant after g request
    // cycles, ready on access cycle r (r >= T never answers), optional flush, optional stall.
    task automatic run_txn(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] wd,
                           input int g, input int r, input logic [DW-1:0] rd,
                           input bit fl, input bit st);
        bus_exp_t be;
        res_exp_t re;
        int       gcnt, acnt, cyc;
        bit       seen_low, done;
        if (fl) begin
            re.busy_len = 2 + g;
            re.err      = 1'b0;
        end else begin
            be.addr  = a;
            be.rw    = rw;
            be.wdata = wd;
            bus_q.push_back(be);
            re.busy_len = 3 + g + ((r < T) ? r : T - 1);
            if (r >= T) begin
                re.err      = 1'b1;
                model_rdata = '0;
            end else begin
                re.err = 1'b0;
                if (rw) model_rdata = rd;
            end
        end
        re.rdata = model_rdata;
        res_q.push_back(re);

        @(negedge clock);
        req = 1'b1; req_address = a; req_read_write = rw; req_write_data = wd;
        stall = st; flush = 1'b0; bus_grant_ = 1'b1; bus_ready_ = 1'b1;
        issued++;
        gcnt = 0; acnt = -1; seen_low = 0; done = 0; cyc = 0;
        while (!done) begin
            @(negedge clock);
            cyc++;
            if (!bus_request_) seen_low = 1;
            if (seen_low && bus_request_) begin
                done = 1;
            end else if (cyc > 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL txn_stuck: got no completion in %0d cycles, required one", cyc);
                done = 1;
            end else if (seen_low) begin
                if (!bus_address_strobe_) acnt = 0;
                else if (acnt >= 0) acnt++;
                if (acnt < 0) begin
                    flush = 1'b0;
                    if (fl && gcnt == g) begin
                        flush      = 1'b1;
                        bus_grant_ = 1'($urandom_range(0, 1));
                    end else begin
                        bus_grant_ = (gcnt >= g) ? 1'b0 : 1'b1;
                    end
                    gcnt++;
                end else begin
                    bus_grant_    = 1'b0;
                    flush         = 1'($urandom_range(0, 1));
                    bus_ready_    = (acnt == r) ? 1'b0 : 1'b1;
                    bus_read_data = (acnt == r) ? rd : $urandom;
                end
            end
        end
        flush = 1'b0; bus_grant_ = 1'b1; bus_ready_ = 1'b1;
        if (st) begin
            repeat (3) @(negedge clock);
        end
        req = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        bit found;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; req = 1'b0;
        req_address = '0; req_read_write = 1'b0; req_write_data = '0;
        bus_grant_ = 1'b1; bus_ready_ = 1'b1; bus_read_data = '0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_request_", 64'(bus_request_), 64'd1);
        check("rst_strobe_", 64'(bus_address_strobe_), 64'd1);
        check("rst_read_write", 64'(bus_read_write), 64'd1);
        check("rst_address", 64'(bus_address), 64'd0);
        check("rst_write_data", 64'(bus_write_data), 64'd0);
        check("rst_read_data", 64'(read_data), 64'd0);
        check("rst_error", 64'(bus_error), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        mon_en = 1;

        run_txn(30'h0000100, 1'b1, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
        run_txn(30'h0001234, 1'b0, 32'hA5A5_0F0F, 4, 1, 32'h1111_2222, 0, 0);
        run_txn(30'h0000200, 1'b1, 32'h0, 1, 2, 32'h3333_4444, 0, 1);
        run_txn(30'h0000300, 1'b1, 32'h0, 0, 99, 32'h5555_6666, 0, 0);
        run_txn(30'h0000400, 1'b1, 32'h0, 2, T - 1, 32'h7777_8888, 0, 0);
        run_txn(30'h0000500, 1'b1, 32'h0, 2, 0, 32'h9999_AAAA, 1, 0);
        run_txn(30'h0000600, 1'b0, 32'hBEEF_CAFE, 0, 99, 32'h0, 0, 1);
        run_txn(30'h0000700, 1'b1, 32'h0, 0, 0, 32'h0BAD_F00D, 1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] wd, rd;
            bit            fl, st, rw;
            a  = AW'($urandom);
            wd = $urandom;
            rd = $urandom;
            rw = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 7) == 0);
            st = !fl && ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            run_txn(a, rw, wd, $urandom_range(0, 5), $urandom_range(0, 5), rd, fl, st);
        end

        run_txn(30'h0000800, 1'b1, 32'h0, 0, 0, 32'hCAFE_F00D, 0, 0);
        repeat (4) @(negedge clock);
        check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        check("res_queue_drained", 64'(res_q.size()), 64'd0);

        // Asynchronous reset in the middle of an access.
        mon_en = 0;
        @(negedge clock);
        req = 1'b1; req_address = 30'h0000900; req_read_write = 1'b1;
        bus_grant_ = 1'b0; bus_ready_ = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            if (!bus_address_strobe_) found = 1;
        end
        check("reset_test_reached_access", 64'(found), 64'd1);
        #2;
        reset = 1'b0;
        req = 1'b0;
        #1;
        check("async_rst_request_", 64'(bus_request_), 64'd1);
        check("async_rst_strobe_", 64'(bus_address_strobe_), 64'd1);
        check("async_rst_read_data", 64'(read_data), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_error", 64'(bus_error), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        bus_grant_ = 1'b1;
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
